// File: rtl/dmem_pkg.sv
// Shared types and default sizing for the data-memory write-buffer responder.
package dmem_pkg;

   localparam int DMEM_DEPTH = 4;
   localparam int DMEM_AW    = 32;
   localparam int DMEM_DW    = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WR   = 2'd1,
      ST_RD   = 2'd2,
      ST_RRET = 2'd3
   } dmem_state_t;

   typedef struct packed {
      logic                 valid;
      logic [DMEM_AW-3:0]   waddr;
      logic [DMEM_DW-1:0]   data;
   } wbuf_entry_t;

endpackage

// File: rtl/wbuf_fifo.sv
// Coalescing store FIFO: ring of word-addressed entries with an associative
// lookup port and in-place data update of the matching entry.
module wbuf_fifo
   import dmem_pkg::*;
#(
   parameter int DEPTH = DMEM_DEPTH,
   parameter int AW    = DMEM_AW,
   parameter int DW    = DMEM_DW
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [AW-3:0] lkp_waddr_i,
   input  logic [DW-1:0] wdata_i,
   input  logic          push_i,
   input  logic          upd_i,
   input  logic          pop_i,
   output logic          hit_o,
   output logic          hit_head_o,
   output logic [DW-1:0] hit_data_o,
   output logic          full_o,
   output logic          empty_o,
   output logic [AW-3:0] head_waddr_o,
   output logic [DW-1:0] head_data_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [DEPTH-1:0] valid_q, valid_d;
   logic [PW-1:0]    head_q, head_d;
   logic [PW-1:0]    tail_q, tail_d;
   logic [CW-1:0]    count_q, count_d;
   logic [PW-1:0]    hit_idx;
   logic [AW-3:0]    waddr_q [DEPTH];
   logic [DW-1:0]    data_q  [DEPTH];

   // Coalescing keeps at most one valid entry per word, so the match is one-hot.
   always_comb begin
      hit_o   = 1'b0;
      hit_idx = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (valid_q[i] && (waddr_q[i] == lkp_waddr_i)) begin
            hit_o   = 1'b1;
            hit_idx = PW'(i);
         end
      end
   end

   assign hit_head_o   = hit_o && (hit_idx == head_q);
   assign hit_data_o   = data_q[hit_idx];
   assign head_waddr_o = waddr_q[head_q];
   assign head_data_o  = data_q[head_q];
   assign full_o       = (count_q == CW'(DEPTH));
   assign empty_o      = (count_q == '0);

   always_comb begin
      valid_d = valid_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (push_i) begin
         valid_d[tail_q] = 1'b1;
         tail_d          = tail_q + 1'b1;
      end
      if (pop_i) begin
         valid_d[head_q] = 1'b0;
         head_d          = head_q + 1'b1;
      end
      case ({push_i, pop_i})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         valid_q <= valid_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Payload storage needs no reset; the valid bits gate every use of it.
   always_ff @(posedge clk) begin
      if (push_i) begin
         waddr_q[tail_q] <= lkp_waddr_i;
         data_q[tail_q]  <= wdata_i;
      end
      if (upd_i) begin
         data_q[hit_idx] <= wdata_i;
      end
   end

endmodule

// File: rtl/dmem_wbuf.sv
// Core data-memory responder: posts stores into a coalescing buffer drained in
// the background, serves load hits from the buffer and stalls on load misses.
module dmem_wbuf
   import dmem_pkg::*;
#(
   parameter int DEPTH = DMEM_DEPTH,
   parameter int AW    = DMEM_AW,
   parameter int DW    = DMEM_DW
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          memwrite,
   input  logic          memread,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] writedata,
   output logic [DW-1:0] readdata,
   output logic          stall,
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic          mem_ack,
   input  logic [DW-1:0] mem_rdata
);

   dmem_state_t   state_q, state_d;
   logic [AW-1:0] mem_addr_q, mem_addr_d;
   logic [DW-1:0] mem_wdata_q, mem_wdata_d;
   logic [DW-1:0] rdata_q, rdata_d;

   logic [AW-3:0] waddr, head_waddr;
   logic [DW-1:0] hit_data, head_data;
   logic          is_load, hit, hit_head, full, empty;
   logic          push, upd, pop, ld_miss, wr_head_block;
   logic          unused_addr_lsb;

   assign waddr           = addr[AW-1:2];
   assign unused_addr_lsb = ^addr[1:0];
   assign is_load         = memread & ~memwrite;

   wbuf_fifo #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .DW    (DW)
   ) u_fifo (
      .clk          (clk),
      .reset        (reset),
      .lkp_waddr_i  (waddr),
      .wdata_i      (writedata),
      .push_i       (push),
      .upd_i        (upd),
      .pop_i        (pop),
      .hit_o        (hit),
      .hit_head_o   (hit_head),
      .hit_data_o   (hit_data),
      .full_o       (full),
      .empty_o      (empty),
      .head_waddr_o (head_waddr),
      .head_data_o  (head_data)
   );

   // The head entry is frozen while its write is in flight to the backing memory.
   assign wr_head_block = memwrite & hit & hit_head & (state_q == ST_WR);
   assign upd           = memwrite & hit & ~wr_head_block;
   assign push          = memwrite & ~hit & ~full;
   assign ld_miss       = is_load & ~hit & (state_q != ST_RRET);
   assign stall         = wr_head_block | (memwrite & ~hit & full) | ld_miss;

   assign readdata  = (state_q == ST_RRET)  ? rdata_q  :
                      (is_load & hit)       ? hit_data : '0;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

   always_comb begin
      state_d     = state_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      rdata_d     = rdata_q;
      mem_req     = 1'b0;
      mem_we      = 1'b0;
      pop         = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (ld_miss) begin
               state_d    = ST_RD;
               mem_addr_d = {waddr, 2'b00};
            end else if (!empty) begin
               state_d     = ST_WR;
               mem_addr_d  = {head_waddr, 2'b00};
               // A store merging into the head this cycle must reach the request.
               mem_wdata_d = (upd && hit_head) ? writedata : head_data;
            end
         end
         ST_WR: begin
            mem_req = 1'b1;
            mem_we  = 1'b1;
            if (mem_ack) begin
               pop     = 1'b1;
               state_d = ST_IDLE;
            end
         end
         ST_RD: begin
            mem_req = 1'b1;
            if (mem_ack) begin
               rdata_d = mem_rdata;
               state_d = ST_RRET;
            end
         end
         ST_RRET: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   always_ff @(posedge clk) begin
      rdata_q <= rdata_d;
   end

endmodule
